// File: rtl/cv32e40p_pkg.sv
// Shared core definitions: RISC-V opcodes, security-marker encoding and
// the marker-inserter state type.
package cv32e40p_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;

  // JAL x0, 0: architecturally a self-jump, recognised downstream as a marker
  localparam logic [31:0] SEC_MARKER_DEFAULT = 32'h0000_006F;

  typedef enum logic [0:0] {
    SM_PASS = 1'b0,
    SM_HOLD = 1'b1
  } sm_state_e;

  function automatic logic is_disc_instr(input logic [31:0] instr);
    logic w_branch;
    logic w_jal;
    logic w_jalr;
    w_branch = (instr[6:0] == OPCODE_BRANCH);
    w_jal    = (instr[6:0] == OPCODE_JAL);
    w_jalr   = (instr[6:0] == OPCODE_JALR) && (instr[14:12] == 3'b000);
    return w_branch || w_jal || w_jalr;
  endfunction

endpackage

// File: rtl/cv32e40p_disc_instr_decoder.sv
// Flags control-flow discontinuities (branch, JAL, JALR); shared between the
// marker inserter and the marker detector.
module cv32e40p_disc_instr_decoder
  import cv32e40p_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_disc_o
);

  assign is_disc_o = is_disc_instr(instr_i);

endmodule

// File: rtl/cv32e40p_security_marker_inserter.sv
// Inserts a security marker into the prefetch->decode stream so that basic
// blocks never exceed MAX_BB_LEN counted instructions; upstream stalls one beat.
module cv32e40p_security_marker_inserter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MAX_BB_LEN = 8,
  parameter int unsigned GUARD      = 2,
  parameter logic [31:0] MARKER     = SEC_MARKER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        marker_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BB_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BB_LEN);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(MAX_BB_LEN - GUARD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (MAX_BB_LEN < 2) begin : g_bad_max_bb_len
    $fatal(1, "MAX_BB_LEN must be at least 2");
  end
  if (GUARD >= MAX_BB_LEN) begin : g_bad_guard
    $fatal(1, "GUARD must be smaller than MAX_BB_LEN");
  end

  sm_state_e        r_state;
  logic             r_out_valid;
  logic             r_out_is_marker;
  logic [31:0]      r_out_instr;
  logic [31:0]      r_hold;
  logic [CNT_W-1:0] r_count;

  logic             w_is_disc;
  logic             w_accept;
  logic             w_fire;
  logic             w_is_zero;
  logic             w_is_mark_word;
  logic             w_counted;
  logic             w_insert;
  logic [CNT_W-1:0] w_count_nxt;

  cv32e40p_disc_instr_decoder u_disc_dec (
    .instr_i   (in_instr_i),
    .is_disc_o (w_is_disc)
  );

  assign in_ready_o     = rst_n && (r_state == SM_PASS) && (!r_out_valid || out_ready_i) && !flush_i;
  assign w_accept       = in_valid_i && in_ready_o;
  assign w_fire         = r_out_valid && out_ready_i;
  assign w_is_zero      = (in_instr_i == 32'h0000_0000);
  assign w_is_mark_word = (in_instr_i == MARKER);
  assign w_counted      = !w_is_zero && !w_is_mark_word;
  assign w_insert       = enable_i && w_counted &&
                          ((r_count == CNT_LIMIT) || (w_is_disc && (r_count >= CNT_GUARD)));

  assign out_valid_o = r_out_valid;
  assign out_instr_o = r_out_instr;
  assign marker_o    = rst_n && r_out_valid && out_ready_i && r_out_is_marker;

  // Next basic-block count; an upstream marker restarts the block, disable parks it at 0
  always_comb begin
    w_count_nxt = r_count;
    if (!enable_i) begin
      w_count_nxt = '0;
    end else if (w_accept && w_is_mark_word) begin
      w_count_nxt = '0;
    end else if (w_accept && w_counted) begin
      w_count_nxt = w_insert ? CNT_ONE : (r_count + CNT_ONE);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Stream state machine with registered output stage and one-word hold buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= SM_PASS;
      r_out_valid     <= 1'b0;
      r_out_is_marker <= 1'b0;
      r_out_instr     <= 32'h0000_0000;
      r_hold          <= 32'h0000_0000;
      r_count         <= '0;
    end else if (flush_i) begin
      r_state         <= SM_PASS;
      r_out_valid     <= 1'b0;
      r_out_is_marker <= 1'b0;
      r_hold          <= 32'h0000_0000;
      r_count         <= '0;
    end else begin
      r_count <= w_count_nxt;
      case (r_state)
        SM_PASS: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            if (w_insert) begin
              r_out_instr     <= MARKER;
              r_out_is_marker <= 1'b1;
              r_hold          <= in_instr_i;
              r_state         <= SM_HOLD;
            end else begin
              r_out_instr     <= in_instr_i;
              r_out_is_marker <= 1'b0;
            end
          end else if (w_fire) begin
            r_out_valid     <= 1'b0;
            r_out_is_marker <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        SM_HOLD: begin
          // The held word follows the marker back-to-back once it is taken
          if (w_fire) begin
            r_out_valid     <= 1'b1;
            r_out_instr     <= r_hold;
            r_out_is_marker <= 1'b0;
            r_hold          <= 32'h0000_0000;
            r_state         <= SM_PASS;
          end else begin
            r_state <= SM_HOLD;
          end
        end
        default: begin
          r_state     <= SM_PASS;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_security_marker_inserter.sv
// Directed bench: a queue-based stream model predicts every downstream word;
// literal output patterns pin the model for each scenario.
module tb_cv32e40p_security_marker_inserter;

  localparam int          MAXL  = 4;
  localparam int          GRD   = 2;
  localparam logic [31:0] MRK   = 32'h0000_006F;
  localparam logic [31:0] ADDI  = 32'h0000_0013;
  localparam logic [31:0] ADDI5 = 32'h0050_0293;
  localparam logic [31:0] BEQ   = 32'h0000_0063;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_instr_i = 32'h0;
  logic        out_ready_i = 1'b1;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic        marker_o;

  cv32e40p_security_marker_inserter #(
    .MAX_BB_LEN (MAXL),
    .GUARD      (GRD),
    .MARKER     (MRK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_instr_o (out_instr_o),
    .marker_o    (marker_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  int          m_count = 0;
  logic [31:0] exp_q[$];
  bit          expm_q[$];
  logic [31:0] log_i[$];
  bit          log_m[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit disc(input logic [31:0] w);
    return (w[1:0] == 2'b11) &&
           ((w[6:2] == 5'b11000) || (w[6:2] == 5'b11011) ||
            ((w[6:2] == 5'b11001) && (w[14:12] == 3'b000)));
  endfunction

  // Stream-level model: what the decoder must see for each accepted word
  task automatic model_accept(input logic [31:0] w, input bit en);
    if (!en) begin
      exp_q.push_back(w); expm_q.push_back(1'b0); m_count = 0;
    end else if (w == 32'h0) begin
      exp_q.push_back(w); expm_q.push_back(1'b0);
    end else if (w == MRK) begin
      exp_q.push_back(w); expm_q.push_back(1'b0); m_count = 0;
    end else if (m_count == MAXL || (disc(w) && m_count >= MAXL - GRD)) begin
      exp_q.push_back(MRK); expm_q.push_back(1'b1);
      exp_q.push_back(w);   expm_q.push_back(1'b0);
      m_count = 1;
    end else begin
      exp_q.push_back(w); expm_q.push_back(1'b0); m_count++;
    end
  endtask

  // Compare process: every downstream transfer against the model, plus stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); expm_q.delete(); m_count = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_instr", out_instr_o, prev_instr);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got %h, expected no transfer", out_instr_o);
        end else begin
          chk("out_instr", out_instr_o, exp_q[0]);
          chk("out_marker", 32'(marker_o), 32'(expm_q[0]));
          void'(exp_q.pop_front()); void'(expm_q.pop_front());
        end
        log_i.push_back(out_instr_o); log_m.push_back(marker_o);
      end else begin
        chk("marker_idle", 32'(marker_o), 32'd0);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_instr = out_instr_o;
      if (flush_i) begin
        exp_q.delete(); expm_q.delete(); m_count = 0; prev_stall = 1'b0;
      end else if (in_valid_i && in_ready_o) begin
        model_accept(in_instr_i, enable_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit acc;
    in_valid_i = 1'b1; in_instr_i = w;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk); acc = in_ready_o;
      if (!acc) stall_cnt++;
      @(posedge clk); #1;
      if (acc) begin
        in_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_n(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) send(w);
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int b = 0; b < 30; b++) begin
      @(negedge clk);
      if (!out_valid_o) begin
        tick();
        return;
      end
      tick();
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(in_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
  endtask

  // Pattern letters: A=ADDI, H=ADDI5, B=BEQ, 0=zero word, M=inserted marker
  task automatic check_seq(input string nm, input string pat);
    logic [31:0] ew;
    chk({nm, "_len"}, 32'(log_i.size()), 32'(pat.len()));
    for (int i = 0; i < pat.len() && i < log_i.size(); i++) begin
      case (pat[i])
        "A":     ew = ADDI;
        "H":     ew = ADDI5;
        "B":     ew = BEQ;
        "0":     ew = 32'h0;
        "M":     ew = MRK;
        default: ew = 32'hFFFF_FFFF;
      endcase
      chk(nm, log_i[i], ew);
      chk({nm, "_mk"}, 32'(log_m[i]), 32'(pat[i] == "M"));
    end
    log_i.delete(); log_m.delete();
  endtask

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_instr", out_instr_o, 32'h0);
    chk("rst_marker", 32'(marker_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd0);
    tick();
    rst_n = 1'b1;

    stall_cnt = 0;
    send_n(ADDI, 10); drain();
    check_seq("ten_addi", "AAAAMAAAAMAA");
    chk("ten_stalls", 32'(stall_cnt), 32'd2);

    do_flush(); log_i.delete(); log_m.delete();
    send_n(ADDI, 2); send(BEQ); send_n(ADDI, 4); drain();
    check_seq("guard_beq", "AAMBAAAMA");

    do_flush();
    send(ADDI); send(BEQ); drain();
    check_seq("early_beq", "AB");

    do_flush();
    for (int k = 0; k < 4; k++) begin send(ADDI); send(32'h0); end
    send(ADDI); drain();
    check_seq("zeros", "A0A0A0A0MA");

    do_flush();
    send_n(ADDI, 4); send(ADDI5);
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_instr", out_instr_o, MRK);
      chk("hold_ready", 32'(in_ready_o), 32'd0);
      tick();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("hold_marker_o", 32'(marker_o), 32'd1);
    tick();
    @(negedge clk);
    chk("held_follows", out_instr_o, ADDI5);
    chk("held_valid", 32'(out_valid_o), 32'd1);
    tick(); drain();
    check_seq("hold", "AAAAMH");

    do_flush();
    send_n(ADDI, 4); send(ADDI5);
    out_ready_i = 1'b0; tick();
    do_flush();
    @(negedge clk);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    tick(); out_ready_i = 1'b1;
    send_n(ADDI, 5); drain();
    check_seq("flush_hold", "AAAAAAAAMA");

    do_flush();
    enable_i = 1'b0;
    send_n(ADDI, 12); drain();
    check_seq("disabled", "AAAAAAAAAAAA");
    enable_i = 1'b1;

    send_n(ADDI, 4); send(ADDI5);
    out_ready_i = 1'b0; tick();
    rst_n = 1'b0; tick();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_instr", out_instr_o, 32'h0);
    chk("mid_rst_marker", 32'(marker_o), 32'd0);
    chk("mid_rst_ready", 32'(in_ready_o), 32'd0);
    tick();
    rst_n = 1'b1; out_ready_i = 1'b1;
    send_n(ADDI, 5); drain();
    check_seq("after_rst", "AAAAAAAAMA");

    chk("leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
